// File: rtl/vec_strided_lsu_if.sv
// rtl/vec_strided_lsu_if.sv - word-wide memory port between the strided LSU and the shared memory
interface vec_strided_lsu_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/vec_strided_lsu.sv
// rtl/vec_strided_lsu.sv - strided vector load/store unit, one word transaction per element
// Packs/unpacks 8/16/32-bit elements between a VLEN-bit register image and memory.
module vec_strided_lsu #(
  parameter int VLEN = 128,
  parameter int VLW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [31:0]       cmd_base,
  input  logic [31:0]       cmd_stride,
  input  logic [VLW-1:0]    cmd_vl,
  input  logic [1:0]        cmd_sew,
  input  logic [VLEN-1:0]   st_data,
  output logic [VLEN-1:0]   ld_data,
  output logic              done,
  output logic              err,
  vec_strided_lsu_if.master mem
);
  localparam int SHW = VLW + 5;

  typedef enum logic [1:0] {IDLE, CHECK, REQ, FIN} state_t;

  state_t          state;
  logic            store;
  logic [31:0]     stride;
  logic [31:0]     addr;
  logic [VLW-1:0]  vl;
  logic [VLW-1:0]  idx;
  logic [1:0]      sew;
  logic [VLEN-1:0] st_buf;

  logic [SHW-1:0]  sh;
  logic [VLEN-1:0] st_shift;
  logic [VLEN-1:0] ld_next;
  logic [31:0]     elem;
  logic [31:0]     mask;
  logic [31:0]     rd;
  logic [31:0]     wdata_c;
  logic [31:0]     max_el;
  logic [3:0]      wstrb_c;
  logic            misaligned;
  logic            too_long;

  // sh is the bit offset of element idx inside the register image
  always_comb begin
    sh       = SHW'(idx) << ({1'b0, sew} + 3'd3);
    st_shift = st_buf >> sh;
    elem     = st_shift[31:0];
    case (sew)
      2'd0: begin
        mask    = 32'h0000_00ff;
        max_el  = 32'(VLEN / 8);
        wdata_c = {4{elem[7:0]}};
        wstrb_c = 4'b0001 << addr[1:0];
      end
      2'd1: begin
        mask    = 32'h0000_ffff;
        max_el  = 32'(VLEN / 16);
        wdata_c = {2{elem[15:0]}};
        wstrb_c = 4'b0011 << addr[1:0];
      end
      default: begin
        mask    = 32'hffff_ffff;
        max_el  = 32'(VLEN / 32);
        wdata_c = elem;
        wstrb_c = 4'b1111;
      end
    endcase
    misaligned = (sew == 2'd1 && addr[0]) || (sew == 2'd2 && addr[1:0] != 2'b00);
    too_long   = (sew == 2'd3) || (32'(vl) > max_el);
    rd         = (mem.rdata >> {addr[1:0], 3'b000}) & mask;
    ld_next    = (ld_data & ~(VLEN'(mask) << sh)) | (VLEN'(rd) << sh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      ld_data   <= '0;
      mem.valid <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.wstrb <= '0;
      store     <= 1'b0;
      stride    <= '0;
      addr      <= '0;
      vl        <= '0;
      idx       <= '0;
      sew       <= '0;
      st_buf    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            store     <= cmd_store;
            stride    <= cmd_stride;
            addr      <= cmd_base;
            vl        <= cmd_vl;
            sew       <= cmd_sew;
            st_buf    <= st_data;
            idx       <= '0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            if (!cmd_store) ld_data <= '0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (vl == '0) begin
            err   <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else if (too_long || misaligned) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            mem.valid <= 1'b1;
            mem.addr  <= {addr[31:2], 2'b00};
            mem.wdata <= store ? wdata_c : 32'h0;
            mem.wstrb <= store ? wstrb_c : 4'b0000;
            state     <= REQ;
          end
        end
        REQ: begin
          // valid drops on the ack edge so the responder never sees a back-to-back request
          if (mem.ready) begin
            mem.valid <= 1'b0;
            if (!store) ld_data <= ld_next;
            idx  <= idx + VLW'(1);
            addr <= addr + stride;
            if (idx + VLW'(1) == vl) begin
              err   <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              state <= CHECK;
            end
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vec_strided_lsu.sv
// tb/tb_vec_strided_lsu.sv - self-checking bench for vec_strided_lsu against a byte-level memory model
module tb_vec_strided_lsu;
  localparam int VLEN = 128;
  localparam int VLW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_store = 1'b0;
  logic [31:0]     cmd_base = '0;
  logic [31:0]     cmd_stride = '0;
  logic [VLW-1:0]  cmd_vl = '0;
  logic [1:0]      cmd_sew = '0;
  logic [VLEN-1:0] st_data = '0;
  logic [VLEN-1:0] ld_data;
  logic            done;
  logic            err;

  vec_strided_lsu_if mem_if();

  vec_strided_lsu #(.VLEN(VLEN), .VLW(VLW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_store(cmd_store), .cmd_base(cmd_base), .cmd_stride(cmd_stride),
    .cmd_vl(cmd_vl), .cmd_sew(cmd_sew), .st_data(st_data), .ld_data(ld_data),
    .done(done), .err(err), .mem(mem_if)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t            obs_q[$];
  txn_t            exp_q[$];
  logic [31:0]     mem[1024];
  logic [31:0]     ref_mem[1024];
  logic [VLEN-1:0] exp_ld = '0;
  bit              exp_err;
  int              exp_lat;
  int              checks = 0;
  int              passed = 0;
  int              accepts = 0;
  int              valid_cycles = 0;
  int              done_cnt = 0;

  always #5 clk = ~clk;

  assign mem_if.rdata = mem[mem_if.addr[11:2]];

  // responder acks one cycle after seeing a request
  always @(posedge clk) begin
    if (reset) mem_if.ready <= 1'b0;
    else       mem_if.ready <= mem_if.valid && !mem_if.ready;
  end

  always @(negedge clk) begin
    if (mem_if.valid) valid_cycles++;
    if (done === 1'b1) done_cnt++;
    if (cmd_valid && cmd_ready === 1'b1 && !reset) accepts++;
    if (mem_if.valid && mem_if.ready) begin
      obs_q.push_back('{addr: mem_if.addr, wstrb: mem_if.wstrb, wdata: mem_if.wdata});
      for (int b = 0; b < 4; b++)
        if (mem_if.wstrb[b]) mem[mem_if.addr[11:2]][8*b +: 8] = mem_if.wdata[8*b +: 8];
    end
  end

  // Reference: walks elements by byte address, keeps its own memory image
  task automatic model_cmd(input bit st, input logic [31:0] base, input logic [31:0] stride,
                           input logic [VLW-1:0] vl, input logic [1:0] sew, input logic [VLEN-1:0] sdata);
    int bytes, sw, maxel, off;
    logic [31:0] a, elem, rep, msk;
    exp_q.delete();
    exp_err = 1'b0;
    if (!st) exp_ld = '0;
    bytes = 1 << sew;
    sw    = 8 * bytes;
    maxel = VLEN / sw;
    msk   = 32'((64'd1 << sw) - 64'd1);
    if (vl == 0) begin exp_lat = 2; return; end
    if (sew == 2'd3 || int'(vl) > maxel) begin exp_err = 1'b1; exp_lat = 2; return; end
    for (int k = 0; k < int'(vl); k++) begin
      a = base + stride * 32'(k);
      if ((a % 32'(bytes)) != 0) begin exp_err = 1'b1; exp_lat = 3 * k + 2; return; end
      off = int'(a % 32'd4);
      if (st) begin
        elem = 32'(sdata >> (k * sw)) & msk;
        for (int b = 0; b < bytes; b++) ref_mem[a[11:2]][8*(off+b) +: 8] = elem[8*b +: 8];
        rep = '0;
        for (int j = 0; j < 4 / bytes; j++) rep = rep | (elem << (j * sw));
        exp_q.push_back('{addr: a & 32'hffff_fffc, wstrb: 4'(((1 << bytes) - 1) << off), wdata: rep});
      end else begin
        elem = (ref_mem[a[11:2]] >> (8 * off)) & msk;
        exp_ld = exp_ld | (VLEN'(elem) << (k * sw));
        exp_q.push_back('{addr: a & 32'hffff_fffc, wstrb: 4'b0000, wdata: 32'h0});
      end
    end
    exp_lat = 3 * int'(vl) + 1;
  endtask

  task automatic run_cmd(input string tag, input bit st, input logic [31:0] base, input logic [31:0] stride,
                         input logic [VLW-1:0] vl, input logic [1:0] sew, input logic [VLEN-1:0] sdata,
                         input bit hold);
    int cyc, nbad;
    model_cmd(st, base, stride, vl, sew, sdata);
    obs_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = st; cmd_base = base; cmd_stride = stride;
    cmd_vl = vl; cmd_sew = sew; st_data = sdata;
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s ready_before_accept: got %b expected 1", tag, cmd_ready);
    else passed++;
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 400) $display("FAIL %s done_timeout: got no done in %0d cycles expected done", tag, cyc);
    else passed++;
    checks++;
    if (cyc + 1 != exp_lat) $display("FAIL %s latency: got %0d expected %0d", tag, cyc + 1, exp_lat);
    else passed++;
    checks++;
    if (err !== exp_err) $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
    else passed++;
    checks++;
    if (ld_data !== exp_ld) $display("FAIL %s ld_data: got %h expected %h", tag, ld_data, exp_ld);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL %s txn_count: got %0d expected %0d", tag, obs_q.size(), exp_q.size());
    else passed++;
    for (int t = 0; t < obs_q.size() && t < exp_q.size(); t++) begin
      checks++;
      if (obs_q[t].addr !== exp_q[t].addr || obs_q[t].wstrb !== exp_q[t].wstrb ||
          (st && obs_q[t].wdata !== exp_q[t].wdata))
        $display("FAIL %s txn%0d: got addr=%h wstrb=%b wdata=%h expected addr=%h wstrb=%b wdata=%h",
                 tag, t, obs_q[t].addr, obs_q[t].wstrb, obs_q[t].wdata,
                 exp_q[t].addr, exp_q[t].wstrb, exp_q[t].wdata);
      else passed++;
    end
    nbad = 0;
    for (int w = 0; w < 1024; w++) if (mem[w] !== ref_mem[w]) nbad++;
    checks++;
    if (nbad != 0) $display("FAIL %s memory_image: got %0d differing words expected 0", tag, nbad);
    else passed++;
    if (hold) begin @(negedge clk); cmd_valid = 1'b0; end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL %s after_done: got done=%b ready=%b expected done=0 ready=1", tag, done, cmd_ready);
    else passed++;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || mem_if.valid !== 1'b0)
      $display("FAIL reset_ctrl: got ready=%b done=%b err=%b valid=%b expected 1 0 0 0",
               cmd_ready, done, err, mem_if.valid);
    else passed++;
    checks++;
    if (mem_if.addr !== 32'h0 || mem_if.wdata !== 32'h0 || mem_if.wstrb !== 4'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%b expected zeros", mem_if.addr, mem_if.wdata, mem_if.wstrb);
    else passed++;
    checks++;
    if (ld_data !== '0) $display("FAIL reset_ld_data: got %h expected 0", ld_data);
    else passed++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_load_stride1();
    run_cmd("load_s1", 1'b0, 32'd400, 32'd1, 8'd4, 2'd0, '0, 1'b0);
    checks++;
    if (ld_data[31:0] !== 32'h02010201 || ld_data[VLEN-1:32] !== '0)
      $display("FAIL load_s1_value: got %h expected 02010201 with upper zero", ld_data);
    else passed++;
  endtask

  task automatic test_load_stride4();
    run_cmd("load_s4", 1'b0, 32'd400, 32'd4, 8'd3, 2'd0, '0, 1'b0);
    checks++;
    if (ld_data[23:0] !== 24'h010001) $display("FAIL load_s4_value: got %h expected 010001", ld_data[23:0]);
    else passed++;
  endtask

  task automatic test_store_neg_stride();
    run_cmd("store_neg", 1'b1, 32'd800, 32'hffff_fffe, 8'd2, 2'd1, {96'h0, 32'hBEEFCAFE}, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0].wstrb !== 4'b0011 || obs_q[1].wstrb !== 4'b1100 ||
        obs_q[0].wdata[15:0] !== 16'hCAFE || obs_q[1].wdata[31:16] !== 16'hBEEF)
      $display("FAIL store_neg_lanes: got %0d txns expected wstrb 0011/1100 with CAFE/BEEF", obs_q.size());
    else passed++;
    checks++;
    if (mem[200][15:0] !== 16'hCAFE || mem[199][31:16] !== 16'hBEEF)
      $display("FAIL store_neg_mem: got %h %h expected CAFE BEEF", mem[200][15:0], mem[199][31:16]);
    else passed++;
  endtask

  task automatic test_errors();
    int v0;
    v0 = valid_cycles;
    run_cmd("err_misalign", 1'b0, 32'd402, 32'd4, 8'd1, 2'd2, '0, 1'b0);
    run_cmd("err_vl0", 1'b1, 32'd400, 32'd4, 8'd0, 2'd0, '1, 1'b0);
    run_cmd("err_vl17", 1'b0, 32'd400, 32'd1, 8'd17, 2'd0, '0, 1'b0);
    run_cmd("err_sew3", 1'b1, 32'd400, 32'd4, 8'd1, 2'd3, '1, 1'b0);
    checks++;
    if (valid_cycles != v0) $display("FAIL err_no_traffic: got %0d valid cycles expected 0", valid_cycles - v0);
    else passed++;
    run_cmd("err_mid_misalign", 1'b0, 32'd400, 32'd3, 8'd3, 2'd1, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int cyc, d0;
    obs_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_base = 32'd400; cmd_stride = 32'd4; cmd_vl = 8'd4; cmd_sew = 2'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (!(obs_q.size() == 1 && mem_if.valid === 1'b1) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 100) $display("FAIL rst_mid_reach_req2: got no second request expected one");
    else passed++;
    d0 = done_cnt;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_if.valid !== 1'b0 || cmd_ready !== 1'b1 || ld_data !== '0)
      $display("FAIL rst_mid_state: got valid=%b ready=%b ld=%h expected 0 1 0", mem_if.valid, cmd_ready, ld_data);
    else passed++;
    @(negedge clk); reset = 1'b0;
    exp_ld = '0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || mem_if.valid !== 1'b0)
      $display("FAIL rst_mid_quiet: got %0d done pulses valid=%b expected 0 and 0", done_cnt - d0, mem_if.valid);
    else passed++;
  endtask

  task automatic test_busy();
    int a0, d0;
    a0 = accepts;
    d0 = done_cnt;
    run_cmd("busy_hold", 1'b0, 32'd404, 32'd4, 8'd3, 2'd2, '0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (accepts - a0 != 1 || done_cnt - d0 != 1)
      $display("FAIL busy_single: got %0d accepts %0d dones expected 1 1", accepts - a0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_random();
    logic [1:0]  sew;
    logic [31:0] base, stride;
    logic [VLW-1:0] vl;
    int bytes, maxel, s;
    for (int n = 0; n < 40; n++) begin
      s     = int'($urandom_range(0, 9));
      sew   = (s == 0) ? 2'd3 : 2'(s % 3);
      bytes = (sew == 2'd3) ? 1 : (1 << sew);
      maxel = (sew == 2'd3) ? 16 : VLEN / (8 * bytes);
      vl    = VLW'($urandom_range(0, maxel + 1));
      base  = $urandom;
      if ($urandom_range(0, 4) != 0) base = base & ~32'(bytes - 1);
      s      = int'($urandom_range(0, 16)) - 8;
      stride = 32'(s * bytes);
      if ($urandom_range(0, 6) == 0) stride = stride + 32'd1;
      run_cmd($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), base, stride, vl, sew,
              {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    end
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) begin
      mem[w] = $urandom;
      ref_mem[w] = mem[w];
    end
    mem[100] = 32'h02010201; ref_mem[100] = 32'h02010201;
    mem[101] = 32'h01030100; ref_mem[101] = 32'h01030100;
    mem[102] = 32'h02010201; ref_mem[102] = 32'h02010201;
    test_reset();
    test_load_stride1();
    test_load_stride4();
    test_store_neg_stride();
    test_errors();
    test_reset_mid();
    test_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
